// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Instruction fetch controller. A fetch is a cache lookup followed, on miss,
//   by four single-byte memory reads assembled little-endian into one 32-bit
//   word. That word is written back to the cache and delivered as a one-cycle
//   if_valid pulse.
//
//   Build option: define ICACHE_EN to enable the cache lookup and fill path.
//   Without it, the LOOKUP state is skipped and cache_query/cache_enable stay
//   low. Every fetch then goes to memory and completes one cycle sooner.
// -----------------------------------------------------------------------------
module inst_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    // fetch request side
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic        if_busy,
    // cache side
    output logic        cache_query,
    output logic [31:0] query_addr,
    input  logic        inst_hit_i,
    input  logic [31:0] cache_inst_i,
    output logic        cache_enable,
    output logic [31:0] inst_addr,
    output logic [31:0] cache_wdata,
    // byte-wide memory side
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_din
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        DRAIN
    } state_t;

`ifdef ICACHE_EN
    localparam state_t START_STATE = LOOKUP;
`else
    localparam state_t START_STATE = MEM_REQ;
`endif

    state_t      state;
    logic [31:0] fetch_addr;
    logic [1:0]  byte_cnt;
    logic [31:0] fill_buf;

    // The fetch is always word aligned, so the low PC bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^if_addr[1:0];

    // Fetch sequencer: state, byte counter, assembly buffer and registered results.
    // NOTE: state is updated with non-blocking assignments only. Every register then
    //       samples pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_addr <= 32'h0;
            byte_cnt   <= 2'd0;
            // NOTE: the assembly buffer is a plain register, not a memory array, so
            //       resetting it is cheap. It also keeps stale bytes from ever being visible.
            fill_buf   <= 32'h0;
            if_valid   <= 1'b0;
            if_inst    <= 32'h0;
        end else if (rdy) begin
            if_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req) begin
                        fetch_addr <= {if_addr[31:2], 2'b00};
                        byte_cnt   <= 2'd0;
                        state      <= START_STATE;
                    end
                end
                LOOKUP: begin
                    if (if_flush) begin
                        state <= IDLE;
                    end else if (inst_hit_i) begin
                        if_valid <= 1'b1;
                        if_inst  <= cache_inst_i;
                        state    <= IDLE;
                    end else begin
                        state <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    // A grant in the flush cycle leaves a response in flight that must be drained.
                    if (mem_gnt) begin
                        state <= if_flush ? DRAIN : MEM_WAIT;
                    end else if (if_flush) begin
                        state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rvalid) begin
                        fill_buf[{byte_cnt, 3'b000} +: 8] <= mem_din;
                        if (if_flush) begin
                            state <= IDLE;
                        end else if (byte_cnt == 2'd3) begin
                            state <= FILL;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= MEM_REQ;
                        end
                    end else if (if_flush) begin
                        state <= DRAIN;
                    end
                end
                FILL: begin
                    if_valid <= 1'b1;
                    if_inst  <= fill_buf;
                    state    <= IDLE;
                end
                DRAIN: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status and memory request decode; addresses read as zero while idle.
    assign if_busy  = (state != IDLE);
    assign mem_req  = (state == MEM_REQ);
    assign mem_addr = mem_req ? (fetch_addr + {30'd0, byte_cnt}) : 32'h0;

`ifdef ICACHE_EN
    // Cache lookup during LOOKUP and a single-cycle fill write during FILL.
    assign cache_query  = (state == LOOKUP);
    assign query_addr   = cache_query ? fetch_addr : 32'h0;
    assign cache_enable = (state == FILL);
    assign inst_addr    = cache_enable ? fetch_addr : 32'h0;
    assign cache_wdata  = cache_enable ? fill_buf : 32'h0;
`else
    // Without a cache the lookup/fill interface is tied off.
    assign cache_query  = 1'b0;
    assign query_addr   = 32'h0;
    assign cache_enable = 1'b0;
    assign inst_addr    = 32'h0;
    assign cache_wdata  = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//   Scoreboard bench for inst_fetch_ctrl. A byte memory responder and a cache
//   model surround the DUT. Each task queues the expected memory reads,
//   deliveries and fills, and the monitors pop and compare them as they occur.
//   Follows the DUT build: define ICACHE_EN for both or neither.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

`ifdef ICACHE_EN
    localparam bit CACHE    = 1'b1;
    localparam int MISS_LAT = 11;
`else
    localparam bit CACHE    = 1'b0;
    localparam int MISS_LAT = 10;
`endif
    localparam int HIT_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        if_busy;
    logic        cache_query;
    logic [31:0] query_addr;
    logic        inst_hit_i   = 1'b0;
    logic [31:0] cache_inst_i = 32'h0;
    logic        cache_enable;
    logic [31:0] inst_addr;
    logic [31:0] cache_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt    = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_din    = 8'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_fill_addr_q[$];
    logic [31:0] exp_fill_data_q[$];
    logic [31:0] cache_m [logic [31:0]];

    int          rd_accepted  = 0;
    int          query_count  = 0;
    int          stall_left   = 0;
    int          stall_cycles = 0;
    int          rv_delay     = 0;
    logic [31:0] stall_addr   = 32'h0;
    logic [31:0] rsp_addr;
    logic [31:0] rd_exp;

    inst_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_busy      (if_busy),
        .cache_query  (cache_query),
        .query_addr   (query_addr),
        .inst_hit_i   (inst_hit_i),
        .cache_inst_i (cache_inst_i),
        .cache_enable (cache_enable),
        .inst_addr    (inst_addr),
        .cache_wdata  (cache_wdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_din      (mem_din)
    );

    always #5 clk = ~clk;

    // Memory contents: the documented program bytes at 0x1004, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_1004: return 8'h13;
            32'h0000_1005: return 8'h05;
            32'h0000_1006: return 8'h10;
            32'h0000_1007: return 8'h00;
            default:       return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Byte memory: grant (or stall) at the negedge, return one byte rv_delay+1 cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && stall_left > 0 && mem_addr == stall_addr) begin
                mem_gnt = 1'b0;
                stall_left--;
                stall_cycles++;
            end else begin
                mem_gnt = 1'b1;
                if (mem_req && rdy && rst) begin
                    rsp_addr = mem_addr;
                    rd_accepted++;
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_read unexpected: got addr %h, none expected", rsp_addr);
                    end else begin
                        rd_exp = exp_rd_q.pop_front();
                        if (rsp_addr !== rd_exp) begin
                            errors++;
                            $display("FAIL mem_read_addr: got %h expected %h", rsp_addr, rd_exp);
                        end
                    end
                    @(posedge clk);
                    repeat (rv_delay) @(posedge clk);
                    #1;
                    mem_rvalid = 1'b1;
                    mem_din    = mem_byte(rsp_addr);
                    @(posedge clk);
                    #1;
                    mem_rvalid = 1'b0;
                    mem_din    = 8'h0;
                end
            end
        end
    end

    // Output monitor and cache model: checks deliveries/fills, answers lookups.
    initial begin
        logic [31:0] e_inst;
        logic [31:0] e_faddr;
        logic [31:0] e_fdata;
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                checks++;
                if (exp_inst_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_valid unexpected: got inst %h, none expected", if_inst);
                end else begin
                    e_inst = exp_inst_q.pop_front();
                    if (if_inst !== e_inst) begin
                        errors++;
                        $display("FAIL if_inst: got %h expected %h", if_inst, e_inst);
                    end
                end
            end
            if (cache_enable === 1'b1) begin
                checks++;
                if (exp_fill_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL cache_fill unexpected: got addr %h data %h", inst_addr, cache_wdata);
                end else begin
                    e_faddr = exp_fill_addr_q.pop_front();
                    e_fdata = exp_fill_data_q.pop_front();
                    if (inst_addr !== e_faddr || cache_wdata !== e_fdata) begin
                        errors++;
                        $display("FAIL cache_fill: got %h/%h expected %h/%h",
                                 inst_addr, cache_wdata, e_faddr, e_fdata);
                    end
                end
                cache_m[inst_addr] = cache_wdata;
            end
            if (cache_query === 1'b1) begin
                query_count++;
                if (cache_m.exists(query_addr)) begin
                    inst_hit_i   = 1'b1;
                    cache_inst_i = cache_m[query_addr];
                end else begin
                    inst_hit_i   = 1'b0;
                    cache_inst_i = 32'h0;
                end
            end else begin
                inst_hit_i   = 1'b0;
                cache_inst_i = 32'h0;
            end
        end
    end

    // One complete fetch: queue expectations, measure latency, poke if_req while busy.
    task automatic do_fetch(input logic [31:0] addr, input int n_reads, input int exp_lat,
                            input logic [31:0] word, input bit fill, input string name);
        logic [31:0] base;
        int lat;
        base = {addr[31:2], 2'b00};
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        for (int i = 0; i < n_reads; i++) exp_rd_q.push_back(base + i);
        exp_inst_q.push_back(word);
        if (fill) begin
            exp_fill_addr_q.push_back(base);
            exp_fill_data_q.push_back(word);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        lat = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 3) begin
                if_req  = 1'b1;
                if_addr = 32'hDEAD_BEE0;
            end else begin
                if_req = 1'b0;
            end
            if (n == 1) begin
                checks++;
                if (if_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: got %b expected 1", name, if_busy);
                end
            end
            if (if_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        if_req = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, exp_lat);
        end
        @(negedge clk);
        checks++;
        if (if_busy !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got busy %b valid %b expected 0 0", name, if_busy, if_valid);
        end
        checks++;
        if (exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s reads_left: got %0d expected 0", name, exp_rd_q.size());
            exp_rd_q.delete();
        end
    endtask

    // Issue a request and return once the given number of reads has been granted.
    task automatic start_until_read(input logic [31:0] addr, input int target, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        @(posedge clk);
        #1;
        if_req = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #2;
            if (rd_accepted == target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_read: got %0d reads expected %0d", rd_accepted, target);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        rdy      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        if_flush = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_valid, if_busy, mem_req, cache_query, cache_enable} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {if_valid, if_busy, mem_req, cache_query, cache_enable});
        end
        checks++;
        if (if_inst !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got inst %h addr %h expected 0 0", if_inst, mem_addr);
        end
        rst = 1'b1;
    endtask

    task automatic test_cold_miss();
        do_fetch(32'h0000_1004, 4, MISS_LAT, 32'h0010_0513, CACHE, "cold_miss");
    endtask

    task automatic test_repeat();
`ifdef ICACHE_EN
        do_fetch(32'h0000_1007, 0, HIT_LAT, 32'h0010_0513, 1'b0, "hit");
`else
        do_fetch(32'h0000_1007, 4, MISS_LAT, 32'h0010_0513, 1'b0, "repeat_miss");
`endif
    endtask

    task automatic test_stall_gnt();
        cache_m.delete();
        stall_addr   = 32'h0000_1006;
        stall_left   = 5;
        stall_cycles = 0;
        do_fetch(32'h0000_1004, 4, MISS_LAT + 5, 32'h0010_0513, CACHE, "stall_gnt");
        checks++;
        if (stall_cycles != 5) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected 5", stall_cycles);
        end
    endtask

    task automatic test_flush_wait();
        bit ok;
        int n_idle;
        rv_delay = 3;
        exp_rd_q.push_back(32'h0000_3000);
        exp_rd_q.push_back(32'h0000_3001);
        start_until_read(32'h0000_3000, rd_accepted + 2, ok);
        if (ok) begin
            if_flush = 1'b1;
            @(posedge clk);
            #1;
            if_flush = 1'b0;
            n_idle = 0;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (if_busy === 1'b0) begin
                    n_idle = n;
                    break;
                end
            end
            checks++;
            if (n_idle != 4) begin
                errors++;
                $display("FAIL drain_len: got idle at %0d expected 4", n_idle);
            end
        end
        rv_delay = 0;
        repeat (2) @(negedge clk);
        do_fetch(32'h0000_2000, 4, MISS_LAT, exp_word(32'h0000_2000), CACHE, "after_flush");
    endtask

    task automatic test_flush_early();
        stall_addr = 32'h0000_4000;
        stall_left = 2;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0000_4000;
        @(posedge clk);
        #1;
        if_req   = 1'b0;
        if_flush = 1'b1;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (if_busy !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL flush_early: got busy %b req %b expected 0 0", if_busy, mem_req);
            end
        end
        stall_left = 0;
    endtask

    task automatic test_rst_midfetch();
        bit ok;
        rv_delay = 2;
        exp_rd_q.push_back(32'h0000_5000);
        start_until_read(32'h0000_5000, rd_accepted + 1, ok);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (if_busy !== 1'b0 || mem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_ctrl: got busy %b req %b valid %b expected 0 0 0",
                     if_busy, mem_req, if_valid);
        end
        checks++;
        if (if_inst !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_rst_data: got inst %h addr %h expected 0 0", if_inst, mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (if_busy !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL late_rvalid: got busy %b req %b expected 0 0", if_busy, mem_req);
            end
        end
        rv_delay = 0;
        do_fetch(32'h0000_7000, 4, MISS_LAT, exp_word(32'h0000_7000), CACHE, "after_rst");
    endtask

    task automatic test_rdy_freeze();
        @(negedge clk);
        rdy     = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_6000;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (if_busy !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL rdy_freeze: got busy %b req %b expected 0 0", if_busy, mem_req);
            end
        end
        if_req = 1'b0;
        rdy    = 1'b1;
        do_fetch(32'h0000_6000, 4, MISS_LAT, exp_word(32'h0000_6000), CACHE, "after_freeze");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_repeat();
        test_stall_gnt();
        test_flush_wait();
        test_flush_early();
        test_rst_midfetch();
        test_rdy_freeze();
        repeat (3) @(negedge clk);
        checks++;
`ifdef ICACHE_EN
        if (query_count == 0) begin
            errors++;
            $display("FAIL cache_query_seen: got %0d expected nonzero", query_count);
        end
`else
        if (query_count != 0) begin
            errors++;
            $display("FAIL cache_query_off: got %0d expected 0", query_count);
        end
`endif
        checks++;
        if (exp_inst_q.size() != 0 || exp_fill_addr_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got inst %0d fill %0d expected 0 0",
                     exp_inst_q.size(), exp_fill_addr_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
